steelhorse_capture_array: RTL

- Synthesizable, parametrised multi-channel receive-capture block for Steelhorse system benches and on-chip debug.
- Each channel snoops one Steelhorse receive-side buffer write port (DATA_ADDR / DATA_RECV / WRITE_DATA_RECV) and one NWPCKT_IRQ_VALID line.
- Stores received words in a per-channel bank and counts packets per channel.
- Runs an arm / trigger / countdown / done sequence, so a bench or the CPU can freeze capture a fixed number of cycles after the Nth packet, then read the banks back through a single read port.

---
 rtl/steelhorse_capture_array.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/steelhorse_capture_array.sv
// Multi-channel receive-capture array: snoops buffer write ports into per-channel banks and runs an
// arm/trigger/countdown/done sequence. Define CAPTURE_SIGNATURE_EN to add the per-channel SIG output.
module steelhorse_capture_array #(
  parameter int CHANNELS     = 2,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 7,
  parameter int TRIGGER_PKTS = 1,
  parameter int HALT_CYCLES  = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ARM,
  input  logic [CHANNELS-1:0]        WR_STROBE,
  input  logic [CHANNELS*10-1:0]     WR_ADDR,
  input  logic [CHANNELS*DATA_W-1:0] WR_DATA,
  input  logic [CHANNELS-1:0]        NWPCKT,
  input  logic                       RD_EN,
  input  logic [2:0]                 RD_CH,
  input  logic [ADDR_W-1:0]          RD_ADDR,
  output logic [DATA_W-1:0]          RD_DATA,
  output logic                       RD_VALID,
  output logic [CHANNELS*8-1:0]      PKT_COUNT,
  output logic [CHANNELS-1:0]        OVERFLOW,
  output logic [1:0]                 STATE,
  output logic                       DONE
`ifdef CAPTURE_SIGNATURE_EN
  ,
  output logic [CHANNELS*32-1:0]     SIG
`endif
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARMED     = 2'd1,
    S_COUNTDOWN = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_cnt, w_cnt_next;
  logic                w_capture, w_arm_start, w_trigger;
  logic [CHANNELS-1:0] w_hit;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  assign w_capture   = (r_state == S_ARMED) || (r_state == S_COUNTDOWN);
  assign w_arm_start = (r_state == S_IDLE) && ARM;
  assign w_trigger   = |w_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic              r_stb_q, r_nw_q, r_ovf;
    logic [9:0]        r_addr_q;
    logic [DATA_W-1:0] r_data_q;
    logic [7:0]        r_pkt, w_pkt_next;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              w_commit, w_send, w_range, w_wr, w_rise;
    logic [DATA_W-1:0] w_rd_acc;

    // Commit fires on the first low cycle after the strobe was high; RST discards it.
    assign w_commit = r_stb_q && !WR_STROBE[g] && w_capture && !RST;
    assign w_send   = r_addr_q[9];
    assign w_range  = ((r_addr_q[8:0] >> ADDR_W) != 9'd0);
    assign w_wr     = w_commit && !w_send && !w_range;
    assign w_rise   = NWPCKT[g] && !r_nw_q;

    assign w_pkt_next = (w_rise && w_capture && (r_pkt != 8'hFF)) ? r_pkt + 8'd1 : r_pkt;
    assign w_hit[g]   = (w_pkt_next >= 8'(TRIGGER_PKTS));

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_stb_q  <= 1'b0;
        r_nw_q   <= 1'b0;
        r_addr_q <= '0;
        r_data_q <= '0;
        r_pkt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        r_stb_q <= WR_STROBE[g];
        r_nw_q  <= NWPCKT[g];
        if (WR_STROBE[g]) begin
          r_addr_q <= WR_ADDR[g*10 +: 10];
          r_data_q <= WR_DATA[g*DATA_W +: DATA_W];
        end
        if (w_arm_start) begin
          r_pkt <= '0;
          r_ovf <= 1'b0;
        end else begin
          r_pkt <= w_pkt_next;
          if (w_commit && !w_send && w_range) r_ovf <= 1'b1;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_addr_q[ADDR_W-1:0]] <= r_data_q;
    end

    // Read mux built as a chain so unselected or out-of-range channels fall through to zero.
    if (g == 0) begin : g_first
      assign w_rd_acc = (RD_CH == 3'(g)) ? r_mem[RD_ADDR] : '0;
    end else begin : g_next
      assign w_rd_acc = (RD_CH == 3'(g)) ? r_mem[RD_ADDR] : g_ch[g-1].w_rd_acc;
    end

    assign PKT_COUNT[g*8 +: 8] = r_pkt;
    assign OVERFLOW[g]         = r_ovf;

`ifdef CAPTURE_SIGNATURE_EN
    logic [31:0] r_sig;
    logic [31:0] w_data32;

    assign w_data32 = 32'(r_data_q);

    always_ff @(posedge CLK) begin
      if (RST || w_arm_start) r_sig <= '0;
      else if (w_wr)          r_sig <= {r_sig[30:0], r_sig[31]} ^ w_data32;
    end

    assign SIG[g*32 +: 32] = r_sig;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: if (ARM) w_state_next = S_ARMED;
      S_ARMED: begin
        if (w_trigger) begin
          if (HALT_CYCLES == 0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_COUNTDOWN;
            w_cnt_next   = 8'(HALT_CYCLES);
          end
        end
      end
      S_COUNTDOWN: begin
        if (r_cnt <= 8'd1) begin
          w_state_next = S_DONE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      default: ;
    endcase
    // Dropping ARM overrides everything, including a same-cycle trigger.
    if (!ARM) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= RD_EN;
      if (RD_EN) r_rd_data <= g_ch[CHANNELS-1].w_rd_acc;
    end
  end

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
  assign STATE    = r_state;
  assign DONE     = (r_state == S_DONE);

endmodule
